// File: rtl/add_fft_if.sv
// Request/result bundle of the additive-FFT evaluator: start/coefficients in,
// done/read-port out. The master drives requests; the slave is the evaluator.
interface add_fft_if #(
  parameter int gf        = 13,
  parameter int numc      = 65,
  parameter int mem_width = 32
);
  localparam int dep_bits = gf - 1 - $clog2(mem_width);

  logic                        start;
  logic [numc*gf-1:0]          coeff_in;
  logic                        rd_en;
  logic [dep_bits-1:0]         rd_addr;
  logic                        done;
  logic [2*mem_width*gf-1:0]   data_out;

  modport master (output start, coeff_in, rd_en, rd_addr, input done, data_out);
  modport slave  (input start, coeff_in, rd_en, rd_addr, output done, data_out);
endinterface

// File: rtl/add_fft.sv
// Evaluates a degree<numc polynomial at every GF(2^gf) element using Horner's
// rule over 2*mem_width parallel lanes, one result word per numc cycles.
module add_fft #(
  parameter int             gf        = 13,
  parameter int             numc      = 65,
  parameter int             mem_width = 32,
  parameter logic [gf-1:0]  poly      = 'h001B
) (
  input  logic      clk,
  input  logic      rst_n,
  add_fft_if.slave  bus
);
  localparam int LANES    = 2 * mem_width;
  localparam int LW       = $clog2(LANES);
  localparam int dep_bits = gf - 1 - $clog2(mem_width);
  localparam int depth    = 1 << dep_bits;
  localparam int JW       = $clog2(numc);
  localparam int HALF     = mem_width * gf;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  state_t                       state_q, state_d;
  logic [numc*gf-1:0]           coeff_q, coeff_d;
  logic [dep_bits-1:0]          addr_q, addr_d;
  logic [JW-1:0]                j_q, j_d;
  logic [LANES-1:0][gf-1:0]     acc_q, acc_d;
  logic [LANES-1:0][gf-1:0]     horner;
  logic [2*HALF-1:0]            data_out_q;
  logic                         we;

  logic [HALF-1:0] mem_a [depth];
  logic [HALF-1:0] mem_b [depth];

  function automatic logic [gf-1:0] gf_mul(input logic [gf-1:0] a, input logic [gf-1:0] b);
    logic [gf-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < gf; i++) begin
      r = {r[gf-2:0], 1'b0} ^ (r[gf-1] ? poly : '0);
      if (b[gf-1-i]) r = r ^ a;
    end
    return r;
  endfunction

  // Lane l of word addr evaluates at alpha = {addr, l}, which covers both the
  // A half (l < mem_width) and the B half of the word.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      horner[l] = gf_mul(acc_q[l], {addr_q, LW'(l)}) ^ coeff_q[int'(j_q)*gf +: gf];
    end
  end

  always_comb begin
    state_d = state_q;
    coeff_d = coeff_q;
    addr_d  = addr_q;
    j_d     = j_q;
    acc_d   = acc_q;
    we      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          coeff_d = bus.coeff_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        addr_d  = '0;
        j_d     = JW'(numc - 1);
        acc_d   = '0;
        state_d = EVAL;
      end
      EVAL: begin
        acc_d = horner;
        if (j_q == '0) begin
          we     = 1'b1;
          acc_d  = '0;
          j_d    = JW'(numc - 1);
          addr_d = addr_q + dep_bits'(1);
          if (addr_q == '1) state_d = DONE;
        end else begin
          j_d = j_q - JW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      coeff_q    <= '0;
      addr_q     <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      coeff_q <= coeff_d;
      addr_q  <= addr_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      if (bus.rd_en) data_out_q <= {mem_b[bus.rd_addr], mem_a[bus.rd_addr]};
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_a[addr_q] <= horner[mem_width-1:0];
      mem_b[addr_q] <= horner[LANES-1:mem_width];
    end
  end

  assign bus.done     = (state_q == DONE);
  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_add_fft.sv
// Randomized self-checking bench for add_fft against a power-sum polynomial model.
module tb_add_fft;
  localparam int GF    = 13;
  localparam int NUMC  = 65;
  localparam int MW    = 32;
  localparam int LANES = 2 * MW;
  localparam int NPTS  = 1 << GF;
  localparam int DEPTH = NPTS / LANES;
  localparam int DB    = GF - 1 - $clog2(MW);
  localparam int DW    = LANES * GF;
  localparam int CW    = NUMC * GF;
  localparam int BOUND = DEPTH * (NUMC + 2) + 8;
  localparam logic [GF-1:0] POLY = 13'h001B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_fft_if #(.gf(GF), .numc(NUMC), .mem_width(MW)) bus ();

  add_fft #(.gf(GF), .numc(NUMC), .mem_width(MW), .poly(POLY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [GF-1:0] r_exp [NPTS];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [GF-1:0] ref_mul(input logic [GF-1:0] a, input logic [GF-1:0] b);
    logic [2*GF-2:0] p;
    logic [2*GF-2:0] full;
    p = '0;
    for (int i = 0; i < GF; i++) if (b[i]) p = p ^ ((2*GF-1)'(a) << i);
    full = (2*GF-1)'({1'b1, POLY});
    for (int k = 2*GF-2; k >= GF; k--) if (p[k]) p = p ^ (full << (k - GF));
    return p[GF-1:0];
  endfunction

  // r_i = sum_j c_j * alpha_i^j, powers built up explicitly
  task automatic build_model(input logic [CW-1:0] c);
    logic [GF-1:0] x, pw, s;
    for (int i = 0; i < NPTS; i++) begin
      x = GF'(i);
      pw = GF'(1);
      s = '0;
      for (int j = 0; j < NUMC; j++) begin
        s = s ^ ref_mul(c[j*GF +: GF], pw);
        pw = ref_mul(pw, x);
      end
      r_exp[i] = s;
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int a);
    logic [DW-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*GF +: GF] = r_exp[a*LANES + l];
    return w;
  endfunction

  function automatic logic [CW-1:0] rand_coeffs();
    logic [CW-1:0] c;
    for (int j = 0; j < NUMC; j++) c[j*GF +: GF] = GF'($urandom);
    return c;
  endfunction

  task automatic pulse_start(input logic [CW-1:0] c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.coeff_in = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.coeff_in = rand_coeffs();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.done && n <= BOUND) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_within_bound"}, DW'(n <= BOUND), DW'(1));
    check({tag, "_done"}, DW'(bus.done), DW'(1));
  endtask

  task automatic read_word(input int a);
    @(negedge clk);
    bus.rd_en = 1'b1;
    bus.rd_addr = DB'(a);
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a);
      check($sformatf("%s_w%0d", tag, a), bus.data_out, exp_word(a));
    end
    @(negedge clk);
    bus.rd_addr = '0;
    @(negedge clk);
    check({tag, "_hold"}, bus.data_out, exp_word(DEPTH - 1));
  endtask

  task automatic full_run(input string tag, input logic [CW-1:0] c);
    pulse_start(c);
    check({tag, "_done_clr"}, DW'(bus.done), DW'(0));
    wait_done(tag);
    build_model(c);
    read_all(tag);
  endtask

  logic [CW-1:0] c1, c2;

  initial begin
    bus.start = 1'b0;
    bus.coeff_in = '0;
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
    void'($urandom(32'h5eed_0fa7));
    repeat (3) @(negedge clk);
    check("rst_done", DW'(bus.done), DW'(0));
    check("rst_data", bus.data_out, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_done", DW'(bus.done), DW'(0));

    c1 = '0;
    c1[0 +: GF] = 13'h0005;
    full_run("const", c1);

    c1 = '0;
    c1[GF +: GF] = 13'h0001;
    full_run("ident", c1);
    read_word(0);
    check("ident_A0_l0", DW'(bus.data_out[0 +: GF]), DW'(0));
    check("ident_A0_l1", DW'(bus.data_out[GF +: GF]), DW'(1));
    check("ident_B0_l0", DW'(bus.data_out[MW*GF +: GF]), DW'(32));

    c1 = '0;
    c1[0 +: GF] = 13'h0001;
    c1[2*GF +: GF] = 13'h0001;
    full_run("sq1", c1);
    read_word(0);
    check("sq1_r2", DW'(bus.data_out[2*GF +: GF]), DW'(5));
    read_word(2);
    check("sq1_r80", DW'(bus.data_out[0 +: GF]), DW'(13'h0037));

    full_run("rand", rand_coeffs());

    c1 = rand_coeffs();
    c2 = rand_coeffs();
    pulse_start(c1);
    repeat (500) @(negedge clk);
    pulse_start(c2);
    check("mid_done_lo", DW'(bus.done), DW'(0));
    wait_done("mid");
    build_model(c1);
    read_all("mid");

    c1 = rand_coeffs();
    pulse_start(c1);
    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_done", DW'(bus.done), DW'(0));
    check("abort_data", bus.data_out, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", DW'(bus.done), DW'(0));
    full_run("post", rand_coeffs());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
